conv_result_reader: RTL and testbench
=====================================

Name: conv_result_reader

Overview:
Consumer side of the convolution engine's ping-pong result path. Accepts signed accumulator results from the convolution datapath into two banks of DEPTH words, alternating banks. Drains each full bank in order as a requantized DATA_WIDTH stream with valid/ready handshake toward the next layer (pooling/activation). Backpressures the convolution side with in_ready when both banks are occupied.

Parameters:
DATA_WIDTH, 8, output word width (signed)
ACC_WIDTH, 20, input accumulator width (signed)
DEPTH, 16, words per bank (power of 2, >=2)
SHIFT, 4, arithmetic right shift applied before saturation (0..ACC_WIDTH-1)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
in_valid  in  1  conv result present
in_ready  out  1  block can accept in_data this cycle
in_data  in  ACC_WIDTH  signed accumulator result
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts
out_data  out  DATA_WIDTH  requantized signed result
out_last  out  1  word is last (index DEPTH-1) of its bank
out_sat  out  1  out_data was clamped
bank_full  out  2  per-bank FULL/DRAINING status (bit0 = bank0)

Behaviour:
- Reset (async): all outputs 0, both banks EMPTY, wr_bank=0, rd_bank=0, wr_ptr=0, rd_ptr=0, drain FSM IDLE. Reset mid-fill or mid-drain discards all data; no partial output after release.
- Per-bank state: EMPTY -> FULL (DEPTH-th write) -> DRAINING (reader selects it) -> EMPTY (out_last accepted).
- Write side: in_ready = (bank[wr_bank] == EMPTY), combinational from registered state. Transfer when in_valid & in_ready: store in_data at mem[wr_bank][wr_ptr], wr_ptr++. At wr_ptr==DEPTH-1 transfer: bank FULL, wr_ptr=0, wr_bank toggles.
- Drain FSM: IDLE, FETCH, HOLD.
  - IDLE: if bank[rd_bank]==FULL -> mark DRAINING, rd_ptr=0, go FETCH.
  - FETCH: synchronous memory read of mem[rd_bank][rd_ptr]; next cycle register requantized result into out_data, out_valid=1, out_last=(rd_ptr==DEPTH-1); go HOLD.
  - HOLD: out_valid, out_data, out_last, out_sat held stable until out_ready. On acceptance: if not last, rd_ptr++, go FETCH. If last, bank -> EMPTY, rd_bank toggles, out_valid=0, go IDLE.
- Throughput: one word per 2 cycles with out_ready tied high. First word appears 2 cycles after the bank becomes FULL.
- Requantize: t = in_data >>> SHIFT (sign-extending). out_data = clamp(t, -2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1). out_sat=1 iff clamped.
- Boundaries:
  - Write filling bank X and reader releasing bank X in the same cycle: the write is not allowed (in_ready was 0). The release takes effect next cycle.
  - Reader releasing bank A while writer completes bank B in the same cycle: both updates apply. The FSM picks up bank B from IDLE the next cycle.
  - out_ready high while out_valid low: ignored.
  - in_valid held with in_ready low: no state change; data not consumed.
- Ordering: output order = input order, strictly alternating banks.

Optional Feature:
CONV_READER_RELU_EN
- Defined: negative values map to 0 before shift/saturation; out_sat only on positive overflow.
- Undefined: plain signed saturation as above.

Decomposition:
- Shared package conv_pkg:
  - bank-state enum (EMPTY, FULL, DRAINING)
  - drain-state enum (IDLE, FETCH, HOLD)
  - requantize function (shift + clamp, RELU variant under macro)
  - default ACC_WIDTH/DATA_WIDTH constants shared with the convolution control
- One sub-module: conv_pp_ram. Dual-bank simple dual-port RAM, 2*DEPTH x ACC_WIDTH, one write port, one registered read port.

Test Plan:
- Fill bank0 with 0..15 <<4, out_ready=1 -> 16 words 0..15, out_last on the 16th, first out_valid 2 cycles after 16th write, bank_full=01 during drain.
- Write 40 words continuously with out_ready=0 -> in_ready drops after word 32, bank_full=11; raise out_ready -> remaining 8 accepted after bank0 drains; output order 0..39.
- in_data=20'h7FFFF and 20'h80000, SHIFT=4 -> out_data 127 / -128, out_sat=1; in_data=-32 -> out_data -2, out_sat=0 (RELU_EN build: 0).
- out_ready toggled randomly during HOLD -> out_data/out_last stable while out_valid & !out_ready; no drops or duplicates.
- Assert reset after 5 writes and mid-drain of 3 words -> all outputs 0 next edge; after release, a new 16-word fill drains correctly from word 0.
- Bank0 last word accepted in the same cycle bank1's 16th write arrives -> bank0 EMPTY, bank1 FULL; bank1 drain starts the following cycle with no lost word.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared types and helpers for the convolution result path.
//   - bank_state_t  : per-bank occupancy (EMPTY -> FULL -> DRAINING -> EMPTY)
//   - drain_state_t : reader FSM states (IDLE, FETCH, HOLD)
//   - requantize()  : arithmetic right shift followed by signed saturation
//   - CONV_ACC_WIDTH / CONV_DATA_WIDTH : default widths shared with conv control
// Build option: define CONV_READER_RELU_EN to clamp negative accumulators to
// zero before the shift; saturation then only flags positive overflow.
package conv_pkg;

  localparam int CONV_ACC_WIDTH  = 20;
  localparam int CONV_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FULL     = 2'd1,
    BANK_DRAINING = 2'd2
  } bank_state_t;

  typedef enum logic [1:0] {
    DRAIN_IDLE  = 2'd0,
    DRAIN_FETCH = 2'd1,
    DRAIN_HOLD  = 2'd2
  } drain_state_t;

  // value carries the clamped result sign-extended to 32 bits; callers keep
  // the low data_width bits (data_width must be below 32).
  typedef struct packed {
    logic signed [31:0] value;
    logic               sat;
  } requant_t;

  // acc must already be sign-extended to 64 bits by the caller.
  function automatic requant_t requantize(input logic signed [63:0] acc,
                                          input int shift,
                                          input int data_width);
    requant_t           r;
    logic signed [63:0] a;
    logic signed [63:0] t;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    a = acc;
`ifdef CONV_READER_RELU_EN
    if (a < 0) a = '0;
`endif
    t     = a >>> shift;
    max_v = (64'sd1 <<< (data_width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (data_width - 1));
    r.sat   = 1'b0;
    r.value = 32'(t);
    if (t > max_v) begin
      r.value = 32'(max_v);
      r.sat   = 1'b1;
    end else if (t < min_v) begin
      r.value = 32'(min_v);
      r.sat   = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_pp_ram.sv
// conv_pp_ram: two banks of DEPTH words stored as one 2*DEPTH x ACC_WIDTH
// simple dual-port RAM. The bank select is the address MSB.
// Ports:
//   clk     in  clock
//   wr_en   in  write strobe
//   wr_addr in  {bank, word} write address
//   wr_data in  write data
//   rd_addr in  {bank, word} read address, sampled every cycle
//   rd_data out registered read data (one cycle after rd_addr)
module conv_pp_ram #(
  parameter int ACC_WIDTH = 20,
  parameter int DEPTH     = 16,
  localparam int ADDR_W   = $clog2(2 * DEPTH)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [ACC_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [ACC_WIDTH-1:0] rd_data
);

  logic [ACC_WIDTH-1:0] mem [2*DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/conv_result_reader.sv
// conv_result_reader: ping-pong consumer of convolution accumulator results.
// The writer fills bank wr_bank word by word; a full bank is drained in order
// as requantized words over a valid/ready stream, alternating banks.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid/in_ready     accumulator input handshake (in_ready = write bank EMPTY)
//   in_data               signed ACC_WIDTH accumulator
//   out_valid/out_ready   output handshake, outputs held while not accepted
//   out_data              requantized signed DATA_WIDTH word
//   out_last              word index DEPTH-1 of its bank
//   out_sat               out_data was clamped
//   bank_full[1:0]        bank i is FULL or DRAINING
// Build option: CONV_READER_RELU_EN selects the ReLU requantizer (see conv_pkg).
module conv_result_reader
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = CONV_DATA_WIDTH,
  parameter int ACC_WIDTH  = CONV_ACC_WIDTH,
  parameter int DEPTH      = 16,
  parameter int SHIFT      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ACC_WIDTH-1:0]  in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_sat,
  output logic [1:0]            bank_full
);

  localparam int PTR_W = $clog2(DEPTH);

  bank_state_t          bank_state_reg [2];
  logic                 wr_bank_reg;
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic                 rd_bank_reg, rd_bank_next;
  logic [PTR_W-1:0]     rd_ptr_reg, rd_ptr_next;
  drain_state_t         drain_reg, drain_next;
  logic                 out_valid_reg, out_valid_next;
  logic [DATA_WIDTH-1:0] out_data_reg, out_data_next;
  logic                 out_last_reg, out_last_next;
  logic                 out_sat_reg, out_sat_next;
  logic                 rd_select, rd_release;
  logic                 wr_fire, wr_done;
  logic [ACC_WIDTH-1:0] ram_rd_data;
  requant_t             q;
  logic                 q_unused_bits;

  assign in_ready = (bank_state_reg[wr_bank_reg] == BANK_EMPTY);
  assign wr_fire  = in_valid & in_ready;
  assign wr_done  = wr_fire && (wr_ptr_reg == PTR_W'(DEPTH - 1));

  // The read address follows the *next* pointer so the word is already in the
  // RAM output register when the FSM sits in FETCH: two cycles per word.
  conv_pp_ram #(
    .ACC_WIDTH (ACC_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_fire),
    .wr_addr ({wr_bank_reg, wr_ptr_reg}),
    .wr_data (in_data),
    .rd_addr ({rd_bank_next, rd_ptr_next}),
    .rd_data (ram_rd_data)
  );

  assign q = requantize({{(64 - ACC_WIDTH){ram_rd_data[ACC_WIDTH-1]}}, ram_rd_data},
                        SHIFT, DATA_WIDTH);
  // Upper bits are only sign extension of the clamped value.
  assign q_unused_bits = ^q.value[31:DATA_WIDTH];

  // Drain FSM: next-state and output-register logic.
  always_comb begin
    drain_next     = drain_reg;
    rd_ptr_next    = rd_ptr_reg;
    rd_bank_next   = rd_bank_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_last_next  = out_last_reg;
    out_sat_next   = out_sat_reg;
    rd_select      = 1'b0;
    rd_release     = 1'b0;
    unique case (drain_reg)
      DRAIN_IDLE: begin
        if (bank_state_reg[rd_bank_reg] == BANK_FULL) begin
          rd_select   = 1'b1;
          rd_ptr_next = '0;
          drain_next  = DRAIN_FETCH;
        end
      end
      DRAIN_FETCH: begin
        out_valid_next = 1'b1;
        out_data_next  = q.value[DATA_WIDTH-1:0];
        out_sat_next   = q.sat;
        out_last_next  = (rd_ptr_reg == PTR_W'(DEPTH - 1));
        drain_next     = DRAIN_HOLD;
      end
      DRAIN_HOLD: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          if (out_last_reg) begin
            rd_release   = 1'b1;
            rd_bank_next = ~rd_bank_reg;
            drain_next   = DRAIN_IDLE;
          end else begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            drain_next  = DRAIN_FETCH;
          end
        end
      end
      default: drain_next = DRAIN_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_reg     <= DRAIN_IDLE;
      rd_ptr_reg    <= '0;
      rd_bank_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
      out_sat_reg   <= 1'b0;
    end else begin
      drain_reg     <= drain_next;
      rd_ptr_reg    <= rd_ptr_next;
      rd_bank_reg   <= rd_bank_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_last_reg  <= out_last_next;
      out_sat_reg   <= out_sat_next;
    end
  end

  // Write pointer wraps naturally at DEPTH (power of two).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      wr_bank_reg <= 1'b0;
    end else if (wr_fire) begin
      wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (wr_done) wr_bank_reg <= ~wr_bank_reg;
    end
  end

  // Completion, selection and release never target the same bank in one
  // cycle (each requires a different current state), so both banks update
  // independently when the reader frees one while the writer fills the other.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) bank_state_reg[i] <= BANK_EMPTY;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wr_done && (wr_bank_reg == 1'(i)))
          bank_state_reg[i] <= BANK_FULL;
        else if (rd_select && (rd_bank_reg == 1'(i)))
          bank_state_reg[i] <= BANK_DRAINING;
        else if (rd_release && (rd_bank_reg == 1'(i)))
          bank_state_reg[i] <= BANK_EMPTY;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank_full
    assign bank_full[gi] = (bank_state_reg[gi] != BANK_EMPTY);
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;
  assign out_sat   = out_sat_reg;

endmodule

// File: tb/tb_conv_result_reader.sv
module tb_conv_result_reader;

  localparam int DW    = 8;
  localparam int AW    = 20;
  localparam int DEPTH = 16;
  localparam int SHIFT = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_sat;
  logic [1:0]    bank_full;

  int total_checks  = 0;
  int passed_checks = 0;

  logic [DW-1:0] got_data [$];
  logic          got_sat  [$];
  logic          got_last [$];

  logic          hold_prev = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last, prev_sat;

  typedef struct {
    logic [AW-1:0] din;
    logic [DW-1:0] exp_data;
    logic          exp_sat;
    logic [DW-1:0] relu_data;
    logic          relu_sat;
  } qvec_t;
  qvec_t qv [16];

  always #5 clk = ~clk;

  conv_result_reader #(
    .DATA_WIDTH (DW),
    .ACC_WIDTH  (AW),
    .DEPTH      (DEPTH),
    .SHIFT      (SHIFT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sat   (out_sat),
    .bank_full (bank_full)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act === exp) passed_checks++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Output monitor: records accepted words, checks hold stability.
  always @(negedge clk) begin
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(prev_data));
        check("hold_last", 32'(out_last), 32'(prev_last));
        check("hold_sat", 32'(out_sat), 32'(prev_sat));
      end
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_sat.push_back(out_sat);
        got_last.push_back(out_last);
        $display("out word %0d: data=0x%0h sat=%0b last=%0b", got_data.size() - 1,
                 out_data, out_sat, out_last);
      end
      hold_prev = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      prev_sat  = out_sat;
    end
  end

  task automatic clear_got();
    got_data.delete();
    got_sat.delete();
    got_last.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic write_word(input logic [AW-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("write_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("in word: data=0x%0h", d);
  endtask

  task automatic wait_outputs(input int n, input string name);
    int cyc;
    cyc = 0;
    while (got_data.size() < n && cyc < 1000) begin
      @(negedge clk); #1;
      cyc++;
    end
    check({name, "_count"}, 32'(got_data.size()), 32'(n));
  endtask

  task automatic check_stream(input int n, input int base, input string name);
    for (int i = 0; i < n && i < got_data.size(); i++) begin
      check({name, "_data"}, 32'(got_data[i]), 32'(base + i));
      check({name, "_last"}, 32'(got_last[i]), 32'((i % DEPTH) == DEPTH - 1));
    end
  endtask

  task automatic pulse_reset_checked(input string name);
    @(posedge clk); #1;
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    check({name, "_valid"}, 32'(out_valid), 32'd0);
    check({name, "_data"}, 32'(out_data), 32'd0);
    check({name, "_last"}, 32'(out_last), 32'd0);
    check({name, "_sat"}, 32'(out_sat), 32'd0);
    check({name, "_bank_full"}, 32'(bank_full), 32'd0);
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int n;
    logic [DW-1:0] ed;
    logic          es;

    qv[0]  = '{20'h7FFFF, 8'h7F, 1'b1, 8'h7F, 1'b1};
    qv[1]  = '{20'h80000, 8'h80, 1'b1, 8'h00, 1'b0};
    qv[2]  = '{20'hFFFE0, 8'hFE, 1'b0, 8'h00, 1'b0};
    qv[3]  = '{20'h007F0, 8'h7F, 1'b0, 8'h7F, 1'b0};
    qv[4]  = '{20'h00800, 8'h7F, 1'b1, 8'h7F, 1'b1};
    qv[5]  = '{20'hFF800, 8'h80, 1'b0, 8'h00, 1'b0};
    qv[6]  = '{20'hFF7F0, 8'h80, 1'b1, 8'h00, 1'b0};
    qv[7]  = '{20'h0000F, 8'h00, 1'b0, 8'h00, 1'b0};
    qv[8]  = '{20'hFFFFF, 8'hFF, 1'b0, 8'h00, 1'b0};
    qv[9]  = '{20'hFFFF0, 8'hFF, 1'b0, 8'h00, 1'b0};
    qv[10] = '{20'hFFFEF, 8'hFE, 1'b0, 8'h00, 1'b0};
    qv[11] = '{20'h00010, 8'h01, 1'b0, 8'h01, 1'b0};
    qv[12] = '{20'h00550, 8'h55, 1'b0, 8'h55, 1'b0};
    qv[13] = '{20'h07FF0, 8'h7F, 1'b1, 8'h7F, 1'b1};
    qv[14] = '{20'hF8010, 8'h80, 1'b1, 8'h00, 1'b0};
    qv[15] = '{20'h00000, 8'h00, 1'b0, 8'h00, 1'b0};

    // ---- reset state ----
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_sat", 32'(out_sat), 32'd0);
    check("rst_bank_full", 32'(bank_full), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    // ---- single bank fill, latency and order ----
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) write_word(AW'(i << 4));
    @(negedge clk);
    check("fill_bank_full", 32'(bank_full), 32'b01);
    check("fill_valid_c1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("fill_valid_c2", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("fill_valid_c3", 32'(out_valid), 32'd1);
    check("fill_first_data", 32'(out_data), 32'd0);
    check("fill_drain_bank_full", 32'(bank_full), 32'b01);
    wait_outputs(DEPTH, "fill");
    check_stream(DEPTH, 0, "fill");
    repeat (3) @(posedge clk); #1;
    clear_got();

    // ---- backpressure: both banks occupied ----
    out_ready = 1'b0;
    for (int i = 0; i < 2 * DEPTH; i++) write_word(AW'(i << 4));
    in_valid = 1'b1;
    in_data  = AW'(32 << 4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_bank_full", 32'(bank_full), 32'b11);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 2 * DEPTH; i < 3 * DEPTH; i++) write_word(AW'(i << 4));
    wait_outputs(3 * DEPTH, "bp");
    check_stream(3 * DEPTH, 0, "bp");
    repeat (3) @(posedge clk); #1;
    clear_got();

    // ---- requantization table ----
    for (int i = 0; i < DEPTH; i++) write_word(qv[i].din);
    wait_outputs(DEPTH, "rq");
    for (int i = 0; i < DEPTH && i < got_data.size(); i++) begin
`ifdef CONV_READER_RELU_EN
      ed = qv[i].relu_data;
      es = qv[i].relu_sat;
`else
      ed = qv[i].exp_data;
      es = qv[i].exp_sat;
`endif
      check($sformatf("rq_data[%0d]", i), 32'(got_data[i]), 32'(ed));
      check($sformatf("rq_sat[%0d]", i), 32'(got_sat[i]), 32'(es));
    end
    repeat (3) @(posedge clk); #1;
    clear_got();

    // ---- random out_ready during HOLD ----
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) write_word(AW'((i * 3 + 1) << 4));
    n = 0;
    while (got_data.size() < DEPTH && n < 2000) begin
      @(posedge clk); #1;
      out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    out_ready = 1'b1;
    check("rnd_count", 32'(got_data.size()), 32'(DEPTH));
    for (int i = 0; i < DEPTH && i < got_data.size(); i++)
      check("rnd_data", 32'(got_data[i]), 32'(i * 3 + 1));
    repeat (3) @(posedge clk); #1;
    clear_got();

    // ---- reader releases bank0 as writer completes bank1 ----
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) write_word(AW'((50 + i) << 4));
    for (int i = 0; i < DEPTH - 1; i++) write_word(AW'((80 + i) << 4));
    wait_outputs(DEPTH - 1, "bnd_pre");
    @(posedge clk); #1;
    out_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(out_valid && out_last) && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("bnd_last_held", 32'(out_valid && out_last), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = AW'((80 + DEPTH - 1) << 4);
    @(negedge clk);
    check("bnd_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bnd_bank_full", 32'(bank_full), 32'b10);
    check("bnd_valid_c1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("bnd_valid_c2", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("bnd_valid_c3", 32'(out_valid), 32'd1);
    check("bnd_first_b1", 32'(out_data), 32'd80);
    wait_outputs(2 * DEPTH, "bnd");
    check_stream(DEPTH, 50, "bnd_b0");
    for (int i = 0; i < DEPTH && DEPTH + i < got_data.size(); i++)
      check("bnd_b1_data", 32'(got_data[DEPTH + i]), 32'(80 + i));
    repeat (3) @(posedge clk); #1;
    clear_got();

    // ---- reset after partial fill, then mid-drain ----
    for (int i = 0; i < 5; i++) write_word(AW'((90 + i) << 4));
    pulse_reset_checked("rst_fill");
    for (int i = 0; i < DEPTH; i++) write_word(AW'((60 + i) << 4));
    wait_outputs(3, "rst_mid_pre");
    pulse_reset_checked("rst_drain");
    clear_got();
    repeat (10) @(negedge clk);
    check("rst_no_output", 32'(got_data.size()), 32'd0);
    check("rst_idle_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH; i++) write_word(AW'((30 + i) << 4));
    wait_outputs(DEPTH, "rst_refill");
    check_stream(DEPTH, 30, "rst_refill");

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
